mul_pack_stage: RTL



---
 rtl/mul_pack_if.sv | 26 ++
 rtl/mul_pack_stage.sv | 77 +++++++
 2 files changed

// File: rtl/mul_pack_if.sv
// mul_pack_if: input operand and packed-result handshake bundle for the multiplier back end
interface mul_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign1;
  logic        sign2;
  logic [7:0]  exp1;
  logic [7:0]  exp2;
  logic [25:0] product;
  logic        carry_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_out;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inv;
  logic        flag_inx;
  modport master (
    output in_valid, sign1, sign2, exp1, exp2, product, carry_out, out_ready,
    input  in_ready, out_valid, fp_out, flag_ovf, flag_unf, flag_inv, flag_inx
  );
  modport slave (
    input  in_valid, sign1, sign2, exp1, exp2, product, carry_out, out_ready,
    output in_ready, out_valid, fp_out, flag_ovf, flag_unf, flag_inv, flag_inx
  );
endinterface

// File: rtl/mul_pack_stage.sv
// mul_pack_stage: exponent add, normalize, RNE round and pack into binary32 over a two-register pipeline
module mul_pack_stage (
  input logic     CLK,
  input logic     nRST,
  mul_pack_if.slave bus
);
  logic        a_valid, b_valid, a_adv, b_adv;
  logic        a_s1, a_s2, a_c;
  logic [7:0]  a_e1, a_e2;
  logic [25:0] a_p;
  logic        s, inv, inf, zero, spec, g, st, inc, ovf, unf;
  logic [22:0] mant;
  logic [23:0] mr;
  logic [9:0]  e_pre, e_rnd;
  logic [31:0] r_fp, fp_q;
  logic [3:0]  r_fl, fl_q;
  assign b_adv = !b_valid || bus.out_ready;
  assign a_adv = !a_valid || b_adv;
  assign bus.in_ready = a_adv;
  assign bus.out_valid = b_valid;
  assign bus.fp_out = fp_q;
  assign {bus.flag_ovf, bus.flag_unf, bus.flag_inv, bus.flag_inx} = fl_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      a_valid <= 1'b0;
      a_s1    <= 1'b0;
      a_s2    <= 1'b0;
      a_e1    <= '0;
      a_e2    <= '0;
      a_p     <= '0;
      a_c     <= 1'b0;
    end else if (a_adv) begin
      a_valid <= bus.in_valid;
      if (bus.in_valid) begin
        a_s1 <= bus.sign1;
        a_s2 <= bus.sign2;
        a_e1 <= bus.exp1;
        a_e2 <= bus.exp2;
        a_p  <= bus.product;
        a_c  <= bus.carry_out;
      end
    end
  assign s     = a_s1 ^ a_s2;
  assign inv   = (a_e1 == 8'hFF && a_e2 == 8'h00) || (a_e1 == 8'h00 && a_e2 == 8'hFF);
  assign inf   = a_e1 == 8'hFF || a_e2 == 8'hFF;
  assign zero  = a_e1 == 8'h00 || a_e2 == 8'h00;
  assign spec  = inv || inf || zero;
  assign mant  = a_c ? a_p[25:3] : a_p[24:2];
  assign g     = a_c ? a_p[2] : a_p[1];
  assign st    = a_c ? (a_p[1] | a_p[0]) : a_p[0];
  assign inc   = g & (st | mant[0]);
  assign mr    = {1'b0, mant} + {23'd0, inc};
  assign e_pre = {2'b00, a_e1} + {2'b00, a_e2} - 10'd127 + {9'd0, a_c};
  // a rounding carry out of the mantissa leaves it zero and bumps the exponent
  assign e_rnd = e_pre + {9'd0, mr[23]};
  assign ovf   = !e_rnd[9] && e_rnd[8:0] >= 9'd255;
  assign unf   = e_rnd[9] || e_rnd == 10'd0;
  assign r_fp  = inv  ? 32'h7FC0_0000 :
                 inf  ? {s, 8'hFF, 23'd0} :
                 zero ? {s, 31'd0} :
                 ovf  ? {s, 8'hFF, 23'd0} :
                 unf  ? {s, 31'd0} :
                        {s, e_rnd[7:0], mr[22:0]};
  assign r_fl  = {!spec && ovf, !spec && !ovf && unf, inv, !spec && (ovf || unf || g || st)};
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      b_valid <= 1'b0;
      fp_q    <= '0;
      fl_q    <= '0;
    end else if (b_adv) begin
      b_valid <= a_valid;
      if (a_valid) begin
        fp_q <= r_fp;
        fl_q <= r_fl;
      end
    end
endmodule
